// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions for the immediate-generation stage: format codes,
// opcode field constants and the default immediate width.
package legv8_pkg;

    localparam int unsigned DefaultDataW = 64;

    typedef enum logic [2:0] {
        FmtNone = 3'd0,
        FmtB    = 3'd1,
        FmtCb   = 3'd2,
        FmtD    = 3'd3,
        FmtI    = 3'd4,
        FmtIw   = 3'd5
    } fmt_e;

    // B format, instr[31:26]
    localparam logic [5:0]  OpB      = 6'b000101;
    localparam logic [5:0]  OpBl     = 6'b100101;
    // CB format, instr[31:24]
    localparam logic [7:0]  OpCbz    = 8'b10110100;
    localparam logic [7:0]  OpCbnz   = 8'b10110101;
    localparam logic [7:0]  OpBcond  = 8'b01010100;
    // D format, instr[31:21]
    localparam logic [10:0] OpLdur   = 11'b11111000010;
    localparam logic [10:0] OpStur   = 11'b11111000000;
    localparam logic [10:0] OpLdursw = 11'b10111000100;
    localparam logic [10:0] OpSturw  = 11'b10111000000;
    // I format, instr[31:22]
    localparam logic [9:0]  OpAddi   = 10'b1001000100;
    localparam logic [9:0]  OpSubi   = 10'b1101000100;
    localparam logic [9:0]  OpAddis  = 10'b1011000100;
    localparam logic [9:0]  OpSubis  = 10'b1111000100;
    localparam logic [9:0]  OpAndi   = 10'b1001001000;
    localparam logic [9:0]  OpOrri   = 10'b1011001000;
    localparam logic [9:0]  OpEori   = 10'b1101001000;
    // IW format, instr[31:23]
    localparam logic [8:0]  OpMovz   = 9'b110100101;
    localparam logic [8:0]  OpMovk   = 9'b111100101;

endpackage

// File: rtl/imm_decode.sv
// Combinational LEGv8 immediate decoder: classifies the instruction format and
// produces the extended (optionally scaled) immediate.
module imm_decode
    import legv8_pkg::*;
#(
    parameter int unsigned DATA_W   = DefaultDataW,
    parameter int unsigned BR_SHIFT = 0
) (
    input  logic [31:0]       instr_i,
    output logic [DATA_W-1:0] imm_o,
    output fmt_e              fmt_o,
    output logic              illegal_o
);

    logic        is_b, is_cb, is_d, is_i, is_iw;
    logic [63:0] imm_full;
    logic        unused_rd;

    assign unused_rd = ^instr_i[4:0];

    assign is_b  = (instr_i[31:26] == OpB) || (instr_i[31:26] == OpBl);
    assign is_cb = (instr_i[31:24] == OpCbz) || (instr_i[31:24] == OpCbnz) ||
                   (instr_i[31:24] == OpBcond);
    assign is_d  = (instr_i[31:21] == OpLdur) || (instr_i[31:21] == OpStur) ||
                   (instr_i[31:21] == OpLdursw) || (instr_i[31:21] == OpSturw);
    assign is_i  = (instr_i[31:22] == OpAddi) || (instr_i[31:22] == OpSubi) ||
                   (instr_i[31:22] == OpAddis) || (instr_i[31:22] == OpSubis) ||
                   (instr_i[31:22] == OpAndi) || (instr_i[31:22] == OpOrri) ||
                   (instr_i[31:22] == OpEori);
    assign is_iw = (instr_i[31:23] == OpMovz) || (instr_i[31:23] == OpMovk);

    // Extension is done at 64 bits; truncation to DATA_W afterwards gives the
    // same result as extending and shifting at the narrower width.
    always_comb begin
        imm_full  = '0;
        fmt_o     = FmtNone;
        illegal_o = 1'b0;
        if (is_b) begin
            fmt_o    = FmtB;
            imm_full = {{38{instr_i[25]}}, instr_i[25:0]};
            if (BR_SHIFT != 0) imm_full = imm_full << 2;
        end else if (is_cb) begin
            fmt_o    = FmtCb;
            imm_full = {{45{instr_i[23]}}, instr_i[23:5]};
            if (BR_SHIFT != 0) imm_full = imm_full << 2;
        end else if (is_d) begin
            fmt_o    = FmtD;
            imm_full = {{55{instr_i[20]}}, instr_i[20:12]};
        end else if (is_i) begin
            fmt_o    = FmtI;
            imm_full = {52'b0, instr_i[21:10]};
        end else if (is_iw) begin
            fmt_o = FmtIw;
            // hw of 2 or 3 places the halfword beyond a 32-bit result
            if (DATA_W == 32 && instr_i[22]) begin
                illegal_o = 1'b1;
            end else begin
                imm_full = {48'b0, instr_i[20:5]} << {instr_i[22:21], 4'b0000};
            end
        end
    end

    assign imm_o = imm_full[DATA_W-1:0];

endmodule

// File: rtl/imm_gen_stage.sv
// Pipeline stage wrapping imm_decode with an output register and a skid
// register; in_ready is registered so it never depends on out_ready.
module imm_gen_stage
    import legv8_pkg::*;
#(
    parameter int unsigned DATA_W   = DefaultDataW,
    parameter int unsigned BR_SHIFT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm,
    output fmt_e              fmt,
    output logic              illegal
);

    logic [DATA_W-1:0] dec_imm;
    fmt_e              dec_fmt;
    logic              dec_ill;

    imm_decode #(
        .DATA_W  (DATA_W),
        .BR_SHIFT(BR_SHIFT)
    ) u_imm_decode (
        .instr_i  (instr),
        .imm_o    (dec_imm),
        .fmt_o    (dec_fmt),
        .illegal_o(dec_ill)
    );

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_imm_q, out_imm_d;
    fmt_e              out_fmt_q, out_fmt_d;
    logic              out_ill_q, out_ill_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_imm_q, skid_imm_d;
    fmt_e              skid_fmt_q, skid_fmt_d;
    logic              skid_ill_q, skid_ill_d;
    logic              in_ready_q, in_ready_d;
    logic              accept, out_free;

    assign accept   = in_valid & in_ready_q;
    assign out_free = ~out_valid_q | out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_ill_d   = skid_ill_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_imm_d    = '0;
            out_fmt_d    = FmtNone;
            out_ill_d    = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            // in_ready is low whenever the skid is full, so no accept here then
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_fmt_d    = skid_fmt_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_imm_d = dec_imm;
                    out_fmt_d = dec_fmt;
                    out_ill_d = dec_ill;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
            skid_ill_d   = dec_ill;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= FmtNone;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FmtNone;
            skid_ill_q   <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_ill_q   <= skid_ill_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign imm       = out_imm_q;
    assign fmt       = out_fmt_q;
    assign illegal   = out_ill_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: three parameterisations share one stimulus
// stream so decode results can be compared at 64/32 bits and with branch scaling.
module tb_imm_gen_stage;
    import legv8_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] instr = '0;

    logic        rdy_a, vld_a, ill_a;
    logic [63:0] imm_a;
    fmt_e        fmt_a;
    logic        rdy_s, vld_s, ill_s;
    logic [63:0] imm_s;
    fmt_e        fmt_s;
    logic        rdy_n, vld_n, ill_n;
    logic [31:0] imm_n;
    fmt_e        fmt_n;

    imm_gen_stage #(.DATA_W(64), .BR_SHIFT(0)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .instr(instr), .out_valid(vld_a), .out_ready(out_ready), .imm(imm_a), .fmt(fmt_a),
        .illegal(ill_a)
    );

    imm_gen_stage #(.DATA_W(64), .BR_SHIFT(1)) u_dut_sh (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_s),
        .instr(instr), .out_valid(vld_s), .out_ready(out_ready), .imm(imm_s), .fmt(fmt_s),
        .illegal(ill_s)
    );

    imm_gen_stage #(.DATA_W(32), .BR_SHIFT(0)) u_dut_32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_n),
        .instr(instr), .out_valid(vld_n), .out_ready(out_ready), .imm(imm_n), .fmt(fmt_n),
        .illegal(ill_n)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam int NV = 10;
    logic [31:0] v_instr [NV];
    logic [63:0] v_imm   [NV];
    logic [63:0] v_imm_s [NV];
    logic [31:0] v_imm_n [NV];
    logic [2:0]  v_fmt   [NV];
    logic        v_ill_n [NV];

    initial begin
        // instr, imm(64), imm(64, scaled), imm(32), fmt, illegal(32)
        v_instr[0] = 32'h17FF_FFFF; v_imm[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        v_imm_s[0] = 64'hFFFF_FFFF_FFFF_FFFC; v_imm_n[0] = 32'hFFFF_FFFF;
        v_fmt[0] = 3'd1; v_ill_n[0] = 1'b0;
        v_instr[1] = 32'hB480_0000; v_imm[1] = 64'hFFFF_FFFF_FFFC_0000;
        v_imm_s[1] = 64'hFFFF_FFFF_FFF0_0000; v_imm_n[1] = 32'hFFFC_0000;
        v_fmt[1] = 3'd2; v_ill_n[1] = 1'b0;
        v_instr[2] = 32'hD2F7_DDE0; v_imm[2] = 64'hBEEF_0000_0000_0000;
        v_imm_s[2] = 64'hBEEF_0000_0000_0000; v_imm_n[2] = 32'h0;
        v_fmt[2] = 3'd5; v_ill_n[2] = 1'b1;
        v_instr[3] = 32'hF850_0000; v_imm[3] = 64'hFFFF_FFFF_FFFF_FF00;
        v_imm_s[3] = 64'hFFFF_FFFF_FFFF_FF00; v_imm_n[3] = 32'hFFFF_FF00;
        v_fmt[3] = 3'd3; v_ill_n[3] = 1'b0;
        v_instr[4] = 32'h912A_F000; v_imm[4] = 64'hABC;
        v_imm_s[4] = 64'hABC; v_imm_n[4] = 32'hABC;
        v_fmt[4] = 3'd4; v_ill_n[4] = 1'b0;
        v_instr[5] = 32'hD2A2_4680; v_imm[5] = 64'h1234_0000;
        v_imm_s[5] = 64'h1234_0000; v_imm_n[5] = 32'h1234_0000;
        v_fmt[5] = 3'd5; v_ill_n[5] = 1'b0;
        v_instr[6] = 32'h0000_0000; v_imm[6] = 64'h0;
        v_imm_s[6] = 64'h0; v_imm_n[6] = 32'h0;
        v_fmt[6] = 3'd0; v_ill_n[6] = 1'b0;
        v_instr[7] = 32'h1400_0010; v_imm[7] = 64'h10;
        v_imm_s[7] = 64'h40; v_imm_n[7] = 32'h10;
        v_fmt[7] = 3'd1; v_ill_n[7] = 1'b0;
        v_instr[8] = 32'h9400_0001; v_imm[8] = 64'h1;
        v_imm_s[8] = 64'h4; v_imm_n[8] = 32'h1;
        v_fmt[8] = 3'd1; v_ill_n[8] = 1'b0;
        v_instr[9] = 32'h5400_0020; v_imm[9] = 64'h1;
        v_imm_s[9] = 64'h4; v_imm_n[9] = 32'h1;
        v_fmt[9] = 3'd2; v_ill_n[9] = 1'b0;

        // Reset state, asserted away from any clock edge
        #1 reset = 1'b1;
        #2;
        check_eq("rst_out_valid", vld_a, 0);
        check_eq("rst_in_ready", rdy_a, 0);
        check_eq("rst_imm", imm_a, 0);
        check_eq("rst_fmt", fmt_a, 0);
        check_eq("rst_illegal", ill_a, 0);
        step();
        #5 reset = 1'b0;
        #1 check_eq("in_ready_low_before_edge", rdy_a, 0);
        step();
        check_eq("in_ready_after_reset", rdy_a, 1);
        check_eq("idle_out_valid", vld_a, 0);

        // Back-to-back transfers with out_ready high: one result per cycle
        in_valid = 1'b1;
        for (int i = 0; i < NV; i++) begin
            instr = v_instr[i];
            step();
            check_eq($sformatf("v%0d_out_valid", i), vld_a, 1);
            check_eq($sformatf("v%0d_in_ready", i), rdy_a, 1);
            check_eq($sformatf("v%0d_imm", i), imm_a, v_imm[i]);
            check_eq($sformatf("v%0d_fmt", i), fmt_a, v_fmt[i]);
            check_eq($sformatf("v%0d_illegal", i), ill_a, 0);
            check_eq($sformatf("v%0d_imm_shift", i), imm_s, v_imm_s[i]);
            check_eq($sformatf("v%0d_imm_w32", i), imm_n, v_imm_n[i]);
            check_eq($sformatf("v%0d_illegal_w32", i), ill_n, v_ill_n[i]);
        end
        in_valid = 1'b0;
        step();
        check_eq("drain_out_valid", vld_a, 0);

        // Stall: three offers, only two fit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h912A_F000;
        step();
        check_eq("stall_a_valid", vld_a, 1);
        check_eq("stall_a_imm", imm_a, 64'hABC);
        check_eq("stall_a_ready", rdy_a, 1);
        instr = 32'h9100_0400;
        step();
        check_eq("stall_b_ready", rdy_a, 0);
        check_eq("stall_b_hold_imm", imm_a, 64'hABC);
        instr = 32'h9100_0800;
        step();
        check_eq("stall_c_ready", rdy_a, 0);
        check_eq("stall_c_hold_imm", imm_a, 64'hABC);
        check_eq("stall_c_hold_fmt", fmt_a, 3'd4);
        out_ready = 1'b1;
        step();
        check_eq("release_b_imm", imm_a, 64'h1);
        check_eq("release_b_valid", vld_a, 1);
        check_eq("release_ready", rdy_a, 1);
        step();
        check_eq("release_c_imm", imm_a, 64'h2);
        check_eq("release_c_valid", vld_a, 1);
        in_valid = 1'b0;
        step();
        check_eq("release_empty", vld_a, 0);

        // Flush with both entries full and a word offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h912A_F000;
        step();
        instr = 32'h9100_0400;
        step();
        check_eq("flush_pre_full", rdy_a, 0);
        flush = 1'b1;
        instr = 32'h9100_0C00;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_out_valid", vld_a, 0);
        check_eq("flush_in_ready", rdy_a, 1);
        // A transfer in the flush cycle is dropped as well
        flush    = 1'b1;
        in_valid = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("flush_xfer_dropped", vld_a, 0);
        step();
        check_eq("flush_never_appears", vld_a, 0);

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hD2F7_DDE0;
        step();
        instr = 32'h9100_0400;
        step();
        in_valid = 1'b0;
        check_eq("pre_reset_valid", vld_a, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_valid", vld_a, 0);
        check_eq("async_rst_imm", imm_a, 0);
        check_eq("async_rst_fmt", fmt_a, 0);
        check_eq("async_rst_ready", rdy_a, 0);
        check_eq("async_rst_illegal_w32", ill_n, 0);
        #2 reset  = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("post_rst_ready", rdy_a, 1);
        check_eq("post_rst_valid", vld_a, 0);
        step();
        check_eq("post_rst_no_skid", vld_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
